// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding and a
// constant-friendly ceiling-log2 used to size select and dwell counters.
package decoder_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seq_state_t;

    // Never returns less than 1 so a one-bit counter still exists for tiny ranges.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// Counts cycles spent at one select value; done pulses for the single cycle
// in which the count sits at TERMINAL-1 while running.
module dwell_counter #(
    parameter int WIDTH    = 2,
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count;

    assign done = run && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives enable/select for an N-output decoder, stepping the select either on a
// timed dwell or on manual step pulses. Optional one-shot scan: SEQ_ONESHOT_EN.
module decoder_scan_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 2,
    parameter int DWELL_CYCLES = 4,
    localparam int SEL_WIDTH   = clog2(NUM_OUTPUTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 auto,
    input  logic                 step,
`ifdef SEQ_ONESHOT_EN
    input  logic                 one_shot,
`endif
    output logic                 enable,
    output logic [SEL_WIDTH-1:0] in,
    output logic                 busy,
    output logic                 wrap
);

    localparam int DWELL_WIDTH = clog2(DWELL_CYCLES);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_OUTPUTS - 1);

    seq_state_t state;
    logic       dwell_clear;
    logic       dwell_done;
    logic       advance;
    logic       finish_at_last;

    // The counter only runs while scanning in auto mode; anything else parks it
    // at zero so re-entering auto mode starts a fresh dwell.
    assign dwell_clear = (state != ST_SCAN) || stop || !auto;
    assign advance     = auto ? dwell_done : step;

    dwell_counter #(
        .WIDTH    (DWELL_WIDTH),
        .TERMINAL (DWELL_CYCLES)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (dwell_clear),
        .run   (auto),
        .done  (dwell_done)
    );

`ifdef SEQ_ONESHOT_EN
    logic one_shot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            one_shot_q <= 1'b0;
        end else if (state == ST_IDLE && start && !stop) begin
            one_shot_q <= one_shot;
        end
    end

    assign finish_at_last = one_shot_q;
`else
    assign finish_at_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            enable <= 1'b0;
            in     <= '0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state  <= ST_SCAN;
                        enable <= 1'b1;
                        in     <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (stop) begin
                        state  <= ST_IDLE;
                        enable <= 1'b0;
                        in     <= '0;
                        busy   <= 1'b0;
                    end else if (advance) begin
                        if (in == LAST_SEL) begin
                            // Explicit reload keeps non-power-of-2 ranges in bounds.
                            in   <= '0;
                            wrap <= 1'b1;
                            if (finish_at_last) begin
                                state  <= ST_IDLE;
                                enable <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end else begin
                            in <= in + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: one 2-output/dwell-4 instance and
// one 3-output/dwell-1 instance, checked cycle by cycle against expected queues.
module tb_decoder_scan_sequencer;

    logic clk;
    logic reset;
    logic start_a, stop_a, auto_a, step_a;
    logic start_b, stop_b, auto_b, step_b;
    logic       en_a, busy_a, wrap_a;
    logic [0:0] in_a;
    logic       en_b, busy_b, wrap_b;
    logic [1:0] in_b;
`ifdef SEQ_ONESHOT_EN
    logic one_shot_a, one_shot_b;
`endif

    // Expected entries: a = {enable, in, busy, wrap}, b = {enable, in[1:0], busy, wrap}
    logic [3:0] exp_a_q[$];
    logic [4:0] exp_b_q[$];

    int vectors;
    int miscompares;

    decoder_scan_sequencer #(.NUM_OUTPUTS(2), .DWELL_CYCLES(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .stop     (stop_a),
        .auto     (auto_a),
        .step     (step_a),
`ifdef SEQ_ONESHOT_EN
        .one_shot (one_shot_a),
`endif
        .enable   (en_a),
        .in       (in_a),
        .busy     (busy_a),
        .wrap     (wrap_a)
    );

    decoder_scan_sequencer #(.NUM_OUTPUTS(3), .DWELL_CYCLES(1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .stop     (stop_b),
        .auto     (auto_b),
        .step     (step_b),
`ifdef SEQ_ONESHOT_EN
        .one_shot (one_shot_b),
`endif
        .enable   (en_b),
        .in       (in_b),
        .busy     (busy_b),
        .wrap     (wrap_b)
    );

    // clock / reset-independent watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick(input string tag);
        logic [3:0] obs_a, e_a;
        logic [4:0] obs_b, e_b;
        @(posedge clk);
        #1;
        if (exp_a_q.size() != 0) begin
            e_a   = exp_a_q.pop_front();
            obs_a = {en_a, in_a, busy_a, wrap_a};
            vectors++;
            assert (obs_a === e_a) else begin
                miscompares++;
                $error("FAIL %s: obs={en,in,busy,wrap}=%b exp=%b", tag, obs_a, e_a);
            end
        end
        if (exp_b_q.size() != 0) begin
            e_b   = exp_b_q.pop_front();
            obs_b = {en_b, in_b, busy_b, wrap_b};
            vectors++;
            assert (obs_b === e_b) else begin
                miscompares++;
                $error("FAIL %s: obs={en,in,busy,wrap}=%b exp=%b", tag, obs_b, e_b);
            end
        end
    endtask

    task automatic ea(input logic [3:0] e, input string tag);
        exp_a_q.push_back(e);
        tick(tag);
    endtask

    task automatic eb(input logic [4:0] e, input string tag);
        exp_b_q.push_back(e);
        tick(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        start_a = 1'b1; stop_a = 1'b0; auto_a = 1'b1; step_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; auto_b = 1'b1; step_b = 1'b0;
`ifdef SEQ_ONESHOT_EN
        one_shot_a = 1'b0; one_shot_b = 1'b0;
`endif

        // reset held with start asserted
        ea(4'b0000, "reset_c1");
        ea(4'b0000, "reset_c2");
        reset = 1'b0; start_a = 1'b0;
        ea(4'b0000, "after_reset");

        // auto scan, dwell 4
        start_a = 1'b1;
        ea(4'b1010, "auto_in0_c1");
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) ea(4'b1010, "auto_in0");
        for (int i = 0; i < 4; i++) ea(4'b1110, "auto_in1");
        ea(4'b1011, "auto_wrap");
        ea(4'b1010, "auto_wrap_clr");
        ea(4'b1010, "auto_in0_b");
        ea(4'b1010, "auto_in0_b");
        ea(4'b1110, "auto_in1_cnt0");
        ea(4'b1110, "auto_in1_cnt1");
        ea(4'b1110, "auto_in1_cnt2");
        stop_a = 1'b1;
        ea(4'b0000, "stop_mid_dwell");
        stop_a = 1'b0;
        start_a = 1'b1; stop_a = 1'b1;
        ea(4'b0000, "start_stop_same");
        start_a = 1'b0; stop_a = 1'b0;
        ea(4'b0000, "idle_hold");

        // manual mode with step pulses during cycles 3 and 9
        auto_a = 1'b0; start_a = 1'b1;
        ea(4'b1010, "man_c1");
        start_a = 1'b0;
        ea(4'b1010, "man_c2");
        ea(4'b1010, "man_c3");
        step_a = 1'b1;
        ea(4'b1110, "man_step1");
        step_a = 1'b0;
        for (int i = 0; i < 5; i++) ea(4'b1110, "man_hold1");
        step_a = 1'b1;
        ea(4'b1011, "man_step_wrap");
        step_a = 1'b0;
        ea(4'b1010, "man_hold0");
        ea(4'b1010, "man_hold0");

        // back to auto: dwell restarts from zero, step ignored
        auto_a = 1'b1;
        ea(4'b1010, "auto_restart_c1");
        step_a = 1'b1;
        ea(4'b1010, "step_ignored_auto");
        step_a = 1'b0;
        ea(4'b1010, "auto_restart_c3");
        ea(4'b1110, "auto_restart_adv");
        ea(4'b1110, "auto_in1_cnt1_b");

        // auto drops mid-dwell: select freezes
        auto_a = 1'b0;
        for (int i = 0; i < 4; i++) ea(4'b1110, "auto_off_freeze");

        // reset mid-scan, then restart; start while scanning is ignored
        reset = 1'b1;
        ea(4'b0000, "reset_in_scan");
        reset = 1'b0; auto_a = 1'b1; start_a = 1'b1;
        ea(4'b1010, "restart_c1");
        ea(4'b1010, "start_in_scan_ignored");
        start_a = 1'b0;
        ea(4'b1010, "restart_c3");
        ea(4'b1010, "restart_c4");
        ea(4'b1110, "restart_adv");
        stop_a = 1'b1;
        ea(4'b0000, "stop_c2");
        stop_a = 1'b0; step_a = 1'b1;
        ea(4'b0000, "step_in_idle");
        step_a = 1'b0;

        // three outputs, dwell 1: non-power-of-2 wrap
        start_b = 1'b1;
        eb(5'b10010, "n3_in0");
        start_b = 1'b0;
        eb(5'b10110, "n3_in1");
        eb(5'b11010, "n3_in2");
        eb(5'b10011, "n3_wrap");
        eb(5'b10110, "n3_in1_b");
        eb(5'b11010, "n3_in2_b");
        eb(5'b10011, "n3_wrap_b");
        stop_b = 1'b1;
        eb(5'b00000, "n3_stop");
        stop_b = 1'b0;

`ifdef SEQ_ONESHOT_EN
        one_shot_b = 1'b1; start_b = 1'b1;
        eb(5'b10010, "os_in0");
        start_b = 1'b0; one_shot_b = 1'b0;
        eb(5'b10110, "os_in1");
        eb(5'b11010, "os_in2");
        eb(5'b00001, "os_end_wrap");
        eb(5'b00000, "os_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
